// File: rtl/mult_pkg.sv
// Shared multiplier-datapath definitions: accumulator state encoding and derived widths.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int unsigned nd(input int unsigned op_w, input int unsigned digit_w);
        return op_w / digit_w;
    endfunction

    function automatic int unsigned maxpos(input int unsigned op_w, input int unsigned digit_w);
        return 2 * (nd(op_w, digit_w) - 1);
    endfunction

    // Kept at least one bit wide so a single-digit operand still has a pos port.
    function automatic int unsigned sh_w(input int unsigned op_w, input int unsigned digit_w);
        int unsigned w;
        w = $clog2(maxpos(op_w, digit_w) + 1);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int unsigned term_w(input int unsigned op_w, input int unsigned digit_w);
        return $clog2(nd(op_w, digit_w) * nd(op_w, digit_w) + 1);
    endfunction

    function automatic int unsigned out_w(input int unsigned op_w);
        return 2 * op_w;
    endfunction

endpackage

// File: rtl/shift_accumulator_if.sv
// Term stream, control and result handshake between the digit-product generator and the accumulator.
interface shift_accumulator_if
    import mult_pkg::*;
#(
    parameter int unsigned OP_W    = 8,
    parameter int unsigned DIGIT_W = 4
);
    localparam int unsigned PP_W   = 2 * DIGIT_W;
    localparam int unsigned SH_W   = sh_w(OP_W, DIGIT_W);
    localparam int unsigned TERM_W = term_w(OP_W, DIGIT_W);
    localparam int unsigned OUT_W  = out_w(OP_W);

    logic              start;
    logic [TERM_W-1:0] num_terms;
    logic              in_valid;
    logic              in_ready;
    logic [PP_W-1:0]   pp;
    logic [SH_W-1:0]   pos;
    logic [OUT_W-1:0]  result;
    logic              result_valid;
    logic              result_ready;
    logic              busy;
    logic              err;

    modport master (
        output start, num_terms, in_valid, pp, pos, result_ready,
        input  in_ready, result, result_valid, busy, err
    );

    modport slave (
        input  start, num_terms, in_valid, pp, pos, result_ready,
        output in_ready, result, result_valid, busy, err
    );

endinterface

// File: rtl/pp_shifter.sv
// Places one partial product at its digit position inside the full-width result.
module pp_shifter
    import mult_pkg::*;
#(
    parameter int unsigned OP_W    = 8,
    parameter int unsigned DIGIT_W = 4
) (
    input  logic [2*DIGIT_W-1:0]         pp,
    input  logic [sh_w(OP_W, DIGIT_W)-1:0] pos,
    output logic [out_w(OP_W)-1:0]       shifted,
    output logic                         out_of_range
);
    localparam int unsigned SH_W   = sh_w(OP_W, DIGIT_W);
    localparam int unsigned OUT_W  = out_w(OP_W);
    localparam int unsigned MAXPOS = maxpos(OP_W, DIGIT_W);

    always_comb begin
        shifted      = '0;
        out_of_range = 1'b0;
        if (pos > SH_W'(MAXPOS)) begin
            out_of_range = 1'b1;
        end else begin
            shifted = OUT_W'(pp) << (32'(pos) * DIGIT_W);
        end
    end

endmodule

// File: rtl/shift_accumulator.sv
// Sequential partial-product accumulator: sums shifted digit products into a 2*OP_W result.
module shift_accumulator
    import mult_pkg::*;
#(
    parameter int unsigned OP_W    = 8,
    parameter int unsigned DIGIT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_accumulator_if.slave bus
);
    localparam int unsigned TERM_W = term_w(OP_W, DIGIT_W);
    localparam int unsigned OUT_W  = out_w(OP_W);

    state_t            state;
    logic [TERM_W-1:0] n_terms;
    logic [TERM_W-1:0] cnt;
    logic [TERM_W-1:0] cnt_next_c;
    logic [OUT_W-1:0]  shifted;
    logic              pos_bad;

    pp_shifter #(
        .OP_W    (OP_W),
        .DIGIT_W (DIGIT_W)
    ) u_pp_shifter (
        .pp           (bus.pp),
        .pos          (bus.pos),
        .shifted      (shifted),
        .out_of_range (pos_bad)
    );

    assign cnt_next_c = cnt + TERM_W'(1);

    // result doubles as the accumulator; in_ready/busy track the state they decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            n_terms          <= '0;
            cnt              <= '0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.in_ready     <= 1'b0;
            bus.busy         <= 1'b0;
            bus.err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.result <= '0;
                        bus.err    <= 1'b0;
                        n_terms    <= bus.num_terms;
                        cnt        <= '0;
                        bus.busy   <= 1'b1;
                        if (bus.num_terms == '0) begin
                            state            <= DONE;
                            bus.result_valid <= 1'b1;
                        end else begin
                            state        <= ACCUM;
                            bus.in_ready <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        bus.result <= bus.result + shifted;
                        cnt        <= cnt_next_c;
                        if (pos_bad) bus.err <= 1'b1;
                        if (cnt_next_c == n_terms) begin
                            state            <= DONE;
                            bus.in_ready     <= 1'b0;
                            bus.result_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state            <= IDLE;
                        bus.result_valid <= 1'b0;
                        bus.busy         <= 1'b0;
                    end
                end
                default: begin
                    state            <= IDLE;
                    bus.result_valid <= 1'b0;
                    bus.in_ready     <= 1'b0;
                    bus.busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
